// File: rtl/fetch_control_unit.sv
// Fetch sequencing and opcode decode for the 9-bit single-cycle core.
// Holds the program counter, resolves branch targets through a small LUT and drives datapath controls.
module fetch_control_unit #(
   parameter int D = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [8:0]   mach_code,
   input  logic         branch_flag,
   input  logic         rel_jump,
   output logic [D-1:0] prog_ctr,
   output logic [D-1:0] target,
   output logic         abs_jump,
   output logic [1:0]   InstType,
   output logic         BranchInst,
   output logic         MemRead,
   output logic         MemWrite,
   output logic         ALUSrc,
   output logic         RegWrite,
   output logic         MemtoReg,
   output logic [3:0]   ALUOp
);

   logic [4:0] op;

   assign op       = mach_code[8:4];
   assign abs_jump = BranchInst & branch_flag;

   // Branch target table; edit the entries here to retarget a program
   always_comb begin
      target = '0;
      case (mach_code[3:0])
         4'd0:    target = D'(0);
         4'd1:    target = D'(16);
         4'd2:    target = D'(32);
         4'd3:    target = D'(48);
         4'd4:    target = D'(64);
         4'd5:    target = D'(80);
         4'd6:    target = D'(96);
         4'd7:    target = D'(112);
         4'd8:    target = D'(128);
         4'd9:    target = D'(144);
         4'd10:   target = D'(160);
         4'd11:   target = D'(176);
         4'd12:   target = D'(192);
         4'd13:   target = D'(208);
         4'd14:   target = D'(224);
         4'd15:   target = D'(240);
         default: target = '0;
      endcase
   end

   always_comb begin
      InstType   = 2'b00;
      BranchInst = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      ALUSrc     = 1'b0;
      RegWrite   = 1'b0;
      MemtoReg   = 1'b0;
      ALUOp      = 4'b0000;
      casez (op)
         5'b00???: begin
            RegWrite = 1'b1;
            ALUSrc   = 1'b1;
            ALUOp    = {1'b0, op[2:0]};
         end
         5'b01000: begin
            BranchInst = 1'b1;
         end
         5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101: begin
            RegWrite = 1'b1;
            ALUSrc   = 1'b1;
            ALUOp    = {1'b1, op[2:0]};
         end
         5'b01110: begin
            MemWrite = 1'b1;
            ALUSrc   = 1'b1;
         end
         5'b10???: begin
            InstType = 2'b10;
            MemRead  = 1'b1;
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         5'b11???: begin
            InstType = 2'b11;
            RegWrite = 1'b1;
         end
         default: begin
            InstType = 2'b00;
         end
      endcase
   end

   // An absolute jump outranks a relative one when both are requested
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         prog_ctr <= '0;
      else if (abs_jump)
         prog_ctr <= target;
      else if (rel_jump)
         prog_ctr <= prog_ctr + target;
      else
         prog_ctr <= prog_ctr + D'(1);
   end

endmodule

// File: tb/tb_fetch_control_unit.sv
// Directed bench for fetch_control_unit: PC sequencing, jumps, wrap, async reset and full opcode decode.
module tb_fetch_control_unit;

   localparam int D = 12;

   logic         clk;
   logic         reset;
   logic [8:0]   mach_code;
   logic         branch_flag;
   logic         rel_jump;
   logic [D-1:0] prog_ctr;
   logic [D-1:0] target;
   logic         abs_jump;
   logic [1:0]   InstType;
   logic         BranchInst;
   logic         MemRead;
   logic         MemWrite;
   logic         ALUSrc;
   logic         RegWrite;
   logic         MemtoReg;
   logic [3:0]   ALUOp;

   int checkCount = 0;
   int failCount  = 0;

   fetch_control_unit #(.D(D)) dut (
      .clk        (clk),
      .reset      (reset),
      .mach_code  (mach_code),
      .branch_flag(branch_flag),
      .rel_jump   (rel_jump),
      .prog_ctr   (prog_ctr),
      .target     (target),
      .abs_jump   (abs_jump),
      .InstType   (InstType),
      .BranchInst (BranchInst),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .ALUSrc     (ALUSrc),
      .RegWrite   (RegWrite),
      .MemtoReg   (MemtoReg),
      .ALUOp      (ALUOp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [8:0] mc, input logic bf, input logic rj);
      mach_code   = mc;
      branch_flag = bf;
      rel_jump    = rj;
      #1;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Expected control word {InstType, BranchInst, MemRead, MemWrite, ALUSrc, RegWrite, MemtoReg, ALUOp}
   function automatic logic [11:0] expDecode(input int op);
      logic [11:0] w;
      logic [4:0]  o;
      o = 5'(op);
      w = '0;
      if (op < 8)
         w = {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, o[2:0]};
      else if (op == 8)
         w = {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
      else if (op <= 13)
         w = {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, o[3:0]};
      else if (op == 14)
         w = {2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
      else if (op == 15)
         w = '0;
      else if (op < 24)
         w = {2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000};
      else
         w = {2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
      return w;
   endfunction

   initial begin
      reset = 1'b0;
      applyStimulus(9'b000000000, 1'b0, 1'b0);
      #2;
      checkOutput("reset_pc", 32'(prog_ctr), 0);
      checkOutput("zero_regwrite", 32'(RegWrite), 1);
      checkOutput("zero_aluop", 32'(ALUOp), 0);
      tick(2);
      checkOutput("reset_hold_pc", 32'(prog_ctr), 0);

      reset = 1'b1;
      tick(5);
      checkOutput("seq_fetch_5", 32'(prog_ctr), 5);

      applyStimulus(9'b010000011, 1'b1, 1'b0);
      checkOutput("br_inst", 32'(BranchInst), 1);
      checkOutput("br_target", 32'(target), 48);
      checkOutput("br_abs_jump", 32'(abs_jump), 1);
      tick(1);
      checkOutput("br_taken_pc", 32'(prog_ctr), 48);
      applyStimulus(9'b010000011, 1'b0, 1'b0);
      checkOutput("br_untaken_abs", 32'(abs_jump), 0);
      tick(1);
      checkOutput("br_untaken_pc", 32'(prog_ctr), 49);

      applyStimulus(9'b010000110, 1'b1, 1'b0);
      tick(1);
      checkOutput("br_to_96", 32'(prog_ctr), 96);
      applyStimulus(9'b011110000, 1'b0, 1'b0);
      tick(4);
      checkOutput("pc_100", 32'(prog_ctr), 100);
      applyStimulus(9'b011110010, 1'b0, 1'b1);
      checkOutput("rel_target", 32'(target), 32);
      checkOutput("rel_abs_off", 32'(abs_jump), 0);
      tick(1);
      checkOutput("rel_jump_132", 32'(prog_ctr), 132);

      applyStimulus(9'b011111111, 1'b0, 1'b1);
      tick(16);
      checkOutput("rel_chain_3972", 32'(prog_ctr), 3972);
      applyStimulus(9'b011111111, 1'b0, 1'b0);
      tick(123);
      checkOutput("pc_4095", 32'(prog_ctr), 4095);
      tick(1);
      checkOutput("wrap_to_0", 32'(prog_ctr), 0);

      applyStimulus(9'b010001111, 1'b1, 1'b1);
      checkOutput("prio_target", 32'(target), 240);
      tick(1);
      checkOutput("prio_abs_wins", 32'(prog_ctr), 240);

      applyStimulus(9'b010000010, 1'b1, 1'b0);
      tick(1);
      checkOutput("br_to_32", 32'(prog_ctr), 32);
      applyStimulus(9'b011110000, 1'b0, 1'b0);
      tick(5);
      checkOutput("pc_37", 32'(prog_ctr), 37);
      reset = 1'b0;
      #1;
      checkOutput("async_reset", 32'(prog_ctr), 0);
      applyStimulus(9'b010000011, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      @(posedge clk);
      #2;
      checkOutput("reset_discards_jump", 32'(prog_ctr), 0);
      reset = 1'b1;
      tick(1);
      checkOutput("release_takes_branch", 32'(prog_ctr), 48);

      for (int op = 0; op < 32; op++) begin
         applyStimulus({5'(op), 4'b0101}, 1'b1, 1'b0);
         checkOutput($sformatf("decode_op%0d", op),
                     32'({InstType, BranchInst, MemRead, MemWrite, ALUSrc, RegWrite, MemtoReg, ALUOp}),
                     32'(expDecode(op)));
         checkOutput($sformatf("absjump_op%0d", op), 32'(abs_jump), (op == 8) ? 1 : 0);
      end

      applyStimulus(9'b001010000, 1'b0, 1'b0);
      checkOutput("spot_00101_aluop", 32'(ALUOp), 5);
      applyStimulus(9'b011100000, 1'b0, 1'b0);
      checkOutput("spot_01110_memwrite", 32'(MemWrite), 1);
      applyStimulus(9'b101100000, 1'b0, 1'b0);
      checkOutput("spot_10110_insttype", 32'(InstType), 2);
      checkOutput("spot_10110_memread", 32'(MemRead), 1);
      checkOutput("spot_10110_memtoreg", 32'(MemtoReg), 1);
      checkOutput("spot_10110_regwrite", 32'(RegWrite), 1);
      applyStimulus(9'b110110111, 1'b0, 1'b0);
      checkOutput("spot_11011_insttype", 32'(InstType), 3);
      checkOutput("spot_11011_regwrite", 32'(RegWrite), 1);
      checkOutput("lut_idx7", 32'(target), 112);

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule

// File: doc/fetch_control_unit.md
# fetch_control_unit

Instruction-fetch sequencing and decode block for the 9-bit single-cycle core. It holds the program counter and maps the 4-bit branch index to an absolute target through a 16-entry lookup table. It also decodes the instruction opcode field into the datapath control signals. It sits between the instruction ROM, which consumes `prog_ctr` and returns `mach_code`, and the register-file/ALU/data-memory datapath, which consumes the control outputs.

## Interface
- `D`, default 12: program counter and branch target width.
- `clk` input, 1 bit: the single system clock; all state changes on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low; `prog_ctr` is cleared to 0 while low.
- `mach_code` input, 9 bits: current instruction from the ROM. Bits [8:4] are the opcode field; bits [3:0] are the branch LUT index.
- `branch_flag` input, 1 bit: registered ALU "one" flag (the branch condition).
- `rel_jump` input, 1 bit: relative-jump enable.
- `prog_ctr` output, D bits: current instruction address.
- `target` output, D bits: LUT entry selected by `mach_code[3:0]`.
- `abs_jump` output, 1 bit: equals `BranchInst & branch_flag`.
- `InstType` output, 2 bits: bit1 selects I-type register fields; bit0 selects immediate write-back.
- `BranchInst`, `MemRead`, `MemWrite`, `ALUSrc`, `RegWrite`, `MemtoReg` outputs, 1 bit each.
- `ALUOp` output, 4 bits: ALU command.

## Operation
Program counter next-state, highest priority first:
- `abs_jump` = 1: load `target`.
- `rel_jump` = 1: load `prog_ctr + target`, modulo 2^D.
- Otherwise: load `prog_ctr + 1`, modulo 2^D (4095 wraps to 0).

Branch LUT:
- Combinational, 16 entries.
- Entry k = 16·k, zero-extended to D bits (entry 0 = 0, entry 15 = 240).
- The table is changed per program by editing the case list; the table width is always D.

Decoder (combinational on `op` = `mach_code[8:4]`):
- Every output not listed for an opcode is 0.
- `00ooo`, R-type ALU: `RegWrite`=1, `ALUSrc`=1, `ALUOp`={0,ooo}, `InstType`=00.
- `01000`, branch: `BranchInst`=1, `ALUOp`=0000, no write enables.
- `01001`–`01101`, R-type ALU: `RegWrite`=1, `ALUSrc`=1, `ALUOp`={1,op[2:0]} (values 9–13).
- `01110`, store byte: `MemWrite`=1, `ALUSrc`=1, `ALUOp`=0000.
- `01111`, nop: all outputs 0.
- `10xxx`, I-type load byte: `InstType`=10, `MemRead`=1, `MemtoReg`=1, `RegWrite`=1, `ALUSrc`=0, `ALUOp`=0000. Bits [6:4] are register fields and are ignored by the decode.
- `11xxx`, movi: `InstType`=11, `RegWrite`=1. Bits [6:4] are the destination and bits [3:0] the immediate; both are ignored by the decode.
- `abs_jump` can be 1 only when `BranchInst`=1.

## Timing
- Decoder, LUT, `target` and `abs_jump` are purely combinational. They follow `mach_code` and `branch_flag` in the same cycle.
- `prog_ctr` updates only on the rising clock edge. Every instruction has one-cycle latency.
- A taken branch sampled at edge N puts `target` on `prog_ctr` after edge N.
- Reset:
  - `reset` low clears `prog_ctr` to 0 immediately, independent of `clk`.
  - Reset asserted mid-branch discards the jump.
  - After `reset` rises, the first clock edge advances to 1, or jumps if a taken branch is present.
- Combinational outputs have no reset value; they track `mach_code`, and with `mach_code` = 0 they decode as R-type `ALUOp` 0000.
- `abs_jump` and `rel_jump` both 1 in the same cycle: the absolute jump wins.
- `branch_flag` = 0 on a branch opcode: `prog_ctr` increments normally.

## Test plan
- Reset then sequential fetch: hold `reset` low, `mach_code`=000000000 → `prog_ctr`=0. Release and clock 5 edges → `prog_ctr`=5.
- Taken branch: `mach_code`=010000011, `branch_flag`=1 → `BranchInst`=1, `target`=48, `abs_jump`=1; next edge → `prog_ctr`=48. Same instruction with `branch_flag`=0 → `prog_ctr` increments.
- Relative jump and wrap:
  - At `prog_ctr`=100, `mach_code[3:0]`=2, `rel_jump`=1 → next edge gives `prog_ctr`=132.
  - At `prog_ctr`=4095 with no jump → next edge gives 0.
- Priority: `abs_jump`=1 and `rel_jump`=1 with `target`=240 → next edge gives `prog_ctr`=240.
- Decode sweep: all 32 opcodes checked against the decode rules above. Spot checks:
  - `00101` → `ALUOp`=0101.
  - `01110` → `MemWrite`=1.
  - `10110` → `InstType`=10, `MemRead`/`MemtoReg`/`RegWrite`=1.
  - `11011` → `InstType`=11, `RegWrite`=1.
- Asynchronous reset mid-run: pull `reset` low between edges at `prog_ctr`=37 → `prog_ctr`=0 before the next edge; it stays 0 while low.
